bp_fe_icache_resp_checker: RTL and testbench

Non-synthesizable scoreboard that sits directly downstream of the I$ wrapper in the FE I$ testbench, consuming its instruction stream. Buffers expected instructions pushed by the trace side in an in-order FIFO. Compares every fetched instruction against the FIFO head and applies optional pseudo-random backpressure toward the I$. Reports matches, mismatches, unexpected responses, timeouts and end-of-test completion.

---
 rtl/bp_fe_icache_resp_checker_if.sv | 24 ++
 rtl/bp_fe_icache_resp_checker.sv | 102 ++++++++++
 tb/tb_bp_fe_icache_resp_checker.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/bp_fe_icache_resp_checker_if.sv
// bp_fe_icache_resp_checker_if: expected-trace, I$ response and status bundle of the response checker
interface bp_fe_icache_resp_checker_if #(parameter int data_width_p = 32);
    logic                    exp_v_i;
    logic [data_width_p-1:0] exp_data_i;
    logic                    exp_ready_o;
    logic                    end_i;
    logic                    data_v_i;
    logic [data_width_p-1:0] data_i;
    logic                    data_ready_o;
    logic                    match_o;
    logic                    mismatch_o;
    logic [15:0]             match_count_o;
    logic                    timeout_o;
    logic                    error_o;
    logic                    done_o;
    modport master (
        output exp_v_i, exp_data_i, end_i, data_v_i, data_i,
        input  exp_ready_o, data_ready_o, match_o, mismatch_o, match_count_o, timeout_o, error_o, done_o
    );
    modport slave (
        input  exp_v_i, exp_data_i, end_i, data_v_i, data_i,
        output exp_ready_o, data_ready_o, match_o, mismatch_o, match_count_o, timeout_o, error_o, done_o
    );
endinterface

// File: rtl/bp_fe_icache_resp_checker.sv
// bp_fe_icache_resp_checker: in-order I$ response scoreboard; BP_FE_ICACHE_CHECKER_STALL_EN adds LFSR backpressure
module bp_fe_icache_resp_checker #(
    parameter int         data_width_p = 32,
    parameter int         els_p        = 16,
    parameter int         timeout_p    = 1024,
    parameter logic [7:0] lfsr_seed_p  = 8'hA5
) (
    input logic clk_i,
    input logic reset_i,
    bp_fe_icache_resp_checker_if.slave bus
);
    localparam int aw = $clog2(els_p);
    localparam int tw = $clog2(timeout_p + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, FAIL} state_e;

    state_e                  state_r, state_n;
    logic [data_width_p-1:0] mem_r [els_p];
    logic [aw:0]             rd_ptr_r, wr_ptr_r;
    logic [tw-1:0]           tmo_cnt_r, tmo_cnt_n;
    logic [15:0]             match_count_r;
    logic ready_en_r, end_seen_r, match_r, mismatch_r, timeout_r, error_r;
    logic empty, full, last, live, stall, enq, acc, deq, unexp, eq, hit, miss, tmo_hit, fail_now;

`ifdef BP_FE_ICACHE_CHECKER_STALL_EN
    logic [7:0] lfsr_r;
    // Fibonacci LFSR (taps 8,6,5,4) free-runs and drives the backpressure pattern
    always_ff @(posedge clk_i or negedge reset_i)
        if (!reset_i) lfsr_r <= lfsr_seed_p;
        else          lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    assign stall = lfsr_r[1:0] == 2'b00;
`else
    logic unused_seed;
    assign unused_seed = ^lfsr_seed_p;
    assign stall       = 1'b0;
`endif

    assign empty    = rd_ptr_r == wr_ptr_r;
    assign full     = (rd_ptr_r[aw] != wr_ptr_r[aw]) && (rd_ptr_r[aw-1:0] == wr_ptr_r[aw-1:0]);
    assign last     = (rd_ptr_r + (aw+1)'(1)) == wr_ptr_r;
    assign live     = (state_r == IDLE) || (state_r == BUSY);
    assign enq      = bus.exp_v_i & bus.exp_ready_o;
    assign acc      = bus.data_v_i & bus.data_ready_o;
    assign deq      = acc & ~empty;
    assign unexp    = acc & (state_r != FAIL) & (empty | (state_r == DONE));
    assign eq       = mem_r[rd_ptr_r[aw-1:0]] == bus.data_i;
    assign hit      = acc & live & ~empty & eq;
    assign miss     = acc & live & ~empty & ~eq;
    assign tmo_cnt_n = (empty | acc | ~live) ? '0 : tmo_cnt_r + tw'(1);
    assign tmo_hit  = live & ~empty & ~acc & (tmo_cnt_n == tw'(timeout_p - 1));
    assign fail_now = unexp | miss | tmo_hit;

    assign bus.exp_ready_o   = ready_en_r & live & ~full;
    assign bus.data_ready_o  = ready_en_r & ((state_r == FAIL) | ~stall);
    assign bus.match_o       = match_r;
    assign bus.mismatch_o    = mismatch_r;
    assign bus.match_count_o = match_count_r;
    assign bus.timeout_o     = timeout_r;
    assign bus.error_o       = error_r;
    assign bus.done_o        = state_r == DONE;

    // Next state: any failure wins, then end-of-test completion, then FIFO occupancy
    always_comb begin
        state_n = state_r;
        if (fail_now)                                           state_n = FAIL;
        else if (state_r == IDLE && end_seen_r && empty)        state_n = DONE;
        else if (state_r == IDLE && enq)                        state_n = BUSY;
        else if (state_r == BUSY && deq && !enq && last)        state_n = IDLE;
    end

    // Expected-instruction storage; contents are only meaningful between the pointers
    always_ff @(posedge clk_i)
        if (enq) mem_r[wr_ptr_r[aw-1:0]] <= bus.exp_data_i;

    // Control state, pointers, compare results and sticky status
    always_ff @(posedge clk_i or negedge reset_i)
        if (!reset_i) begin
            state_r       <= IDLE;
            rd_ptr_r      <= '0;
            wr_ptr_r      <= '0;
            tmo_cnt_r     <= '0;
            match_count_r <= '0;
            ready_en_r    <= 1'b0;
            end_seen_r    <= 1'b0;
            match_r       <= 1'b0;
            mismatch_r    <= 1'b0;
            timeout_r     <= 1'b0;
            error_r       <= 1'b0;
        end else begin
            state_r    <= state_n;
            ready_en_r <= 1'b1;
            if (enq) wr_ptr_r <= wr_ptr_r + (aw+1)'(1);
            if (deq) rd_ptr_r <= rd_ptr_r + (aw+1)'(1);
            tmo_cnt_r  <= tmo_cnt_n;
            end_seen_r <= end_seen_r | bus.end_i;
            match_r    <= hit;
            mismatch_r <= unexp | miss;
            timeout_r  <= timeout_r | tmo_hit;
            error_r    <= error_r | fail_now;
            if (hit && match_count_r != '1) match_count_r <= match_count_r + 16'd1;
        end
endmodule

// File: tb/tb_bp_fe_icache_resp_checker.sv
// tb_bp_fe_icache_resp_checker: directed and random checks of the I$ response checker against a queue model
module tb_bp_fe_icache_resp_checker;
    localparam int els_lp     = 16;
    localparam int timeout_lp = 1024;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   n_enq   = 0;

    logic [31:0] q[$];
    bit          started, failed, done_m, end_seen, tmo_m, mt_m, mm_m;
    int          wait_m, cnt_m;
    logic [7:0]  lfsr_m;

    always #5 clk_i = ~clk_i;

    bp_fe_icache_resp_checker_if #(.data_width_p(32)) bus();

    bp_fe_icache_resp_checker #(
        .data_width_p(32), .els_p(els_lp), .timeout_p(timeout_lp), .lfsr_seed_p(8'hA5)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit exp_rdy_m();
        return started && !failed && !done_m && q.size() < els_lp;
    endfunction

    function automatic bit dat_rdy_m();
`ifdef BP_FE_ICACHE_CHECKER_STALL_EN
        return started && (failed || lfsr_m[1:0] != 2'b00);
`else
        return started;
`endif
    endfunction

    task automatic check_outs();
        check("exp_ready", bus.exp_ready_o, exp_rdy_m());
        check("data_ready", bus.data_ready_o, dat_rdy_m());
        check("match", bus.match_o, mt_m);
        check("mismatch", bus.mismatch_o, mm_m);
        check("match_count", bus.match_count_o, cnt_m);
        check("timeout", bus.timeout_o, tmo_m);
        check("error", bus.error_o, failed);
        check("done", bus.done_o, done_m);
    endtask

    // one clock: drive at negedge, advance the model at posedge, compare at next negedge
    task automatic cycle(input bit ev, input logic [31:0] ed, input bit dv, input logic [31:0] dd, input bit en);
        bit enq, acc, pre_empty, tmo_now;
        bus.exp_v_i = ev; bus.exp_data_i = ed; bus.data_v_i = dv; bus.data_i = dd; bus.end_i = en;
        enq = ev && exp_rdy_m();
        acc = dv && dat_rdy_m();
        @(posedge clk_i);
        mt_m = 0; mm_m = 0; tmo_now = 0;
        pre_empty = q.size() == 0;
        if (!failed) begin
            if (acc) begin
                if (pre_empty || done_m)      mm_m = 1;
                else if (q.pop_front() == dd) mt_m = 1;
                else                          mm_m = 1;
            end
            if (!done_m && !pre_empty && !acc) wait_m++;
            else                               wait_m = 0;
            tmo_now = wait_m == timeout_lp - 1;
            if (tmo_now) tmo_m = 1;
            if (enq) begin q.push_back(ed); n_enq++; end
            if (mm_m || tmo_now) failed = 1;
            else if (!done_m && end_seen && pre_empty) done_m = 1;
            if (mt_m && cnt_m < 65535) cnt_m++;
            end_seen = end_seen || en;
        end
        started = 1;
        lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        @(negedge clk_i);
        check_outs();
    endtask

    task automatic reset_dut();
        @(negedge clk_i);
        #2;
        reset_i = 1'b0;
        bus.exp_v_i = 0; bus.exp_data_i = '0; bus.data_v_i = 0; bus.data_i = '0; bus.end_i = 0;
        #1;
        check("rst_exp_ready", bus.exp_ready_o, 0);
        check("rst_data_ready", bus.data_ready_o, 0);
        check("rst_match", bus.match_o, 0);
        check("rst_mismatch", bus.mismatch_o, 0);
        check("rst_count", bus.match_count_o, 0);
        check("rst_timeout", bus.timeout_o, 0);
        check("rst_error", bus.error_o, 0);
        check("rst_done", bus.done_o, 0);
        q.delete();
        started = 0; failed = 0; done_m = 0; end_seen = 0; tmo_m = 0; mt_m = 0; mm_m = 0;
        wait_m = 0; cnt_m = 0; n_enq = 0; lfsr_m = 8'hA5;
        @(negedge clk_i);
        reset_i = 1'b1;
        cycle(0, 0, 0, 0, 0);
    endtask

    // present one response (optionally with an enqueue) on a cycle the checker will accept it
    task automatic respond(input bit ev, input logic [31:0] ed, input logic [31:0] dd);
        for (int k = 0; k < 64; k++) begin
            if (dat_rdy_m()) begin
                cycle(ev, ed, 1, dd, 0);
                return;
            end
            cycle(0, 0, 0, 0, 0);
        end
        check("resp_wait", dat_rdy_m(), 1);
    endtask

    initial begin
        bus.exp_v_i = 0; bus.exp_data_i = '0; bus.data_v_i = 0; bus.data_i = '0; bus.end_i = 0;

        reset_dut();
        cycle(1, 32'h00000013, 0, 0, 0);
        cycle(1, 32'h00100093, 0, 0, 0);
        cycle(1, 32'h00200113, 0, 0, 0);
        respond(0, 0, 32'h00000013);
        respond(0, 0, 32'h00100093);
        respond(0, 0, 32'h00200113);
        cycle(0, 0, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 0, 0);
        check("t1_count", bus.match_count_o, 3);
        check("t1_done", bus.done_o, 1);
        check("t1_error", bus.error_o, 0);

        reset_dut();
        cycle(1, 32'h00000013, 0, 0, 0);
        respond(0, 0, 32'h00000033);
        check("t2_mismatch", bus.mismatch_o, 1);
        check("t2_error", bus.error_o, 1);
        cycle(0, 0, 0, 0, 0);
        check("t2_exp_ready", bus.exp_ready_o, 0);

        reset_dut();
        respond(1, 32'hDEADBEEF, 32'hDEADBEEF);
        check("t3_unexpected", bus.mismatch_o, 1);
        check("t3_error", bus.error_o, 1);

        reset_dut();
        for (int i = 0; i < els_lp; i++) cycle(1, 32'h1000 + i, 0, 0, 0);
        check("t4_full", bus.exp_ready_o, 0);
        for (int i = 0; i < 20; i++) if (q.size() > 0) respond(1, $urandom, q[0]);
        while (q.size() > 0 && !failed) respond(0, 0, q[0]);
        check("t4_count", bus.match_count_o, n_enq);
        check("t4_error", bus.error_o, 0);

        reset_dut();
        cycle(1, 32'h00000013, 0, 0, 0);
        repeat (timeout_lp - 2) cycle(0, 0, 0, 0, 0);
        check("t5_no_timeout_yet", bus.timeout_o, 0);
        cycle(0, 0, 0, 0, 0);
        check("t5_timeout", bus.timeout_o, 1);
        check("t5_error", bus.error_o, 1);

        for (int r = 0; r < 6; r++) begin
            reset_dut();
            for (int c = 0; c < 300; c++) begin
                bit          ev, dv;
                logic [31:0] dd;
                if (r == 3 && c == 150) reset_dut();
                ev = (c <= 250) && $urandom_range(0, 1) == 1;
                dv = (q.size() > 0 && $urandom_range(0, 9) < 7) || $urandom_range(0, 299) == 0;
                dd = q.size() > 0 ? q[0] : $urandom;
                if ($urandom_range(0, 299) == 0) dd = ~dd;
                cycle(ev, $urandom, dv, dd, c == 250);
            end
            while (q.size() > 0 && !failed) respond(0, 0, q[0]);
            repeat (3) cycle(0, 0, 0, 0, 0);
            if (!failed) check("rand_done", bus.done_o, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
